// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // z_out field positions: {remainder, quotient}
    localparam int QUO_LSB = 0;
    localparam int REM_LSB = WIDTH_DEF;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes (combinational).
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_dvsr,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quo
);
    logic [W:0] w_sh;
    logic [W:0] w_sub;
    logic       w_ge;

    // One extra bit keeps the shifted remainder exact before the compare.
    assign w_sh  = {i_rem, i_quo[W-1]};
    assign w_ge  = (w_sh >= {1'b0, i_dvsr});
    assign w_sub = w_sh - {1'b0, i_dvsr};
    assign o_rem = w_ge ? w_sub[W-1:0] : w_sh[W-1:0];
    assign o_quo = {i_quo[W-2:0], w_ge};
endmodule

// File: rtl/seq_div_unit.sv
// Multi-cycle signed divider producing {remainder, quotient} for the Z register.
// Optional DIV_BYZERO_FLAG_EN: zero divisor skips iteration and raises dbz with done.
module seq_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = div_pkg::WIDTH_DEF,
    parameter int CNT_W = div_pkg::CNT_W_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] z_out,
    output logic               dbz
);
    state_t             r_state, w_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_z;

    logic [WIDTH-1:0]   w_dvd_mag, w_dvs_mag;
    logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
    logic               w_last;

    // Negating the most negative value yields itself, read as unsigned magnitude.
    assign w_dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign w_last    = (r_cnt == CNT_W'(WIDTH-1));
    assign w_quo_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    div_step #(.W(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_quo  (r_quo),
        .i_dvsr (r_dvsr),
        .o_rem  (w_rem_nxt),
        .o_quo  (w_quo_nxt)
    );

`ifdef DIV_BYZERO_FLAG_EN
    logic r_zero;
    logic w_zero;
    assign w_zero = (divisor == '0);
    assign dbz    = r_zero && (r_state == DONE);
`else
    assign dbz    = 1'b0;
`endif

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
`ifdef DIV_BYZERO_FLAG_EN
                    w_nxt = w_zero ? FIX : ITER;
`else
                    w_nxt = ITER;
`endif
                end
            end
            ITER:    if (w_last) w_nxt = FIX;
            FIX:     w_nxt = DONE;
            DONE:    w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_z     <= '0;
`ifdef DIV_BYZERO_FLAG_EN
            r_zero  <= 1'b0;
`endif
        end else begin
            r_state <= w_nxt;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rem   <= '0;
                        r_quo   <= w_dvd_mag;
                        r_dvsr  <= w_dvs_mag;
                        r_neg_r <= dividend[WIDTH-1];
                        r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_cnt   <= '0;
`ifdef DIV_BYZERO_FLAG_EN
                        r_zero  <= w_zero;
                        // Preload what a full run with a zero divisor would leave behind.
                        if (w_zero) begin
                            r_rem <= w_dvd_mag;
                            r_quo <= '1;
                        end
`endif
                    end
                end
                ITER: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX:     r_z <= {w_rem_fix, w_quo_fix};
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != IDLE);
    assign done  = (r_state == DONE);
    assign z_out = r_z;
endmodule

// File: tb/tb_seq_div_unit.sv
// Directed self-checking bench for seq_div_unit.
module tb_seq_div_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, dbz;
    logic [63:0] z_out;

    int n_chk = 0;
    int n_err = 0;

    seq_div_unit dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .z_out    (z_out),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r, input int repulse);
        int lat;
        logic exp_dbz;
        lat = -1;
        exp_dbz = 1'b0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0003;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k == 1) chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
            if (done) begin
                lat = k;
                break;
            end
            if (k == repulse) begin
                dividend = 32'd5;
                divisor  = 32'd1;
                start    = 1'b1;
            end
        end
`ifdef DIV_BYZERO_FLAG_EN
        if (b == 32'd0) begin
            exp_dbz = 1'b1;
            chk({tag, "_lat"}, {63'd0, (lat == 1 || lat == 2)}, 64'd1);
        end else
            chk({tag, "_lat"}, 64'(lat), 64'd33);
`else
        chk({tag, "_lat"}, 64'(lat), 64'd33);
`endif
        chk({tag, "_z"}, z_out, {r, q});
        chk({tag, "_dbz"}, {63'd0, dbz}, {63'd0, exp_dbz});
        @(posedge clk);
        #1;
        chk({tag, "_done1"}, {62'd0, done, busy}, 64'd0);
        chk({tag, "_hold"}, z_out[REM_LSB +: 32], r);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", {60'd0, busy, done, dbz, |z_out}, 64'd0);
        @(negedge clk);
        clr = 1'b1;

        run_div("d100_7",   32'd100,       32'd7,         32'd14,        32'd2,         0);
        run_div("dm10_3",   32'hFFFF_FFF6, 32'd3,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_div("d2_m10",   32'd2,         32'hFFFF_FFF6, 32'd0,         32'd2,         0);
        run_div("dm100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 0);
        run_div("dmin_m1",  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         0);
        run_div("d7_0",     32'd7,         32'd0,         32'hFFFF_FFFF, 32'd7,         0);
        run_div("dm7_0",    32'hFFFF_FFF9, 32'd0,         32'd1,         32'hFFFF_FFF9, 0);
        run_div("repulse",  32'd100,       32'd7,         32'd14,        32'd2,         5);

        // Abort a run at iteration 10; the previous result must be wiped.
        @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst", {61'd0, busy, done, dbz}, 64'd0);
        chk("midrst_z", z_out, 64'd0);
        @(negedge clk);
        clr = 1'b1;
        run_div("d9_2", 32'd9, 32'd2, 32'd4, 32'd1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
